divu16x8_seq: RTL and testbench
===============================

// Module: divu16x8_seq
// PURPOSE
//  Iterative unsigned divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient + 8-bit remainder.
//  Inverse of the 8x8 unsigned multiplier: given a 16-bit product and one operand, it recovers the other.
//  Radix-2 restoring algorithm, one quotient bit per clock.
//  Valid/ready handshake on both sides, so it can sit in a streaming datapath.
// PARAMETERS
//  DVD_W  16  dividend width; fixed at 2*DVS_W
//  DVS_W  8   divisor, quotient and remainder width; also the iteration count
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      dividend/divisor are valid
//  in_ready     out  1      block can accept an operation
//  dividend     in   DVD_W  unsigned dividend
//  divisor      in   DVS_W  unsigned divisor
//  out_valid    out  1      result outputs are valid
//  out_ready    in   1      consumer accepts the result
//  quotient     out  DVS_W  unsigned quotient
//  remainder    out  DVS_W  unsigned remainder
//  div_by_zero  out  1      divisor was 0
//  overflow     out  1      true quotient does not fit in DVS_W bits
// BEHAVIOUR
//  Reset (async assert, sync deassert at the boundary): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0,
//   div_by_zero=0, overflow=0. An operation in flight is discarded and nothing is emitted.
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid, latch the operands and go to CALC; when an exception is detected, go to DONE instead.
//   CALC: in_ready=0. Iteration counter runs 0..DVS_W-1.
//    Each cycle: partial remainder r (DVS_W+1 bits) = {r[DVS_W-1:0], next dividend bit, MSB first}; t = r - divisor.
//    If t >= 0: r=t, qbit=1; else qbit=0. The quotient shift register takes qbit.
//    After iteration DVS_W-1 -> DONE.
//   DONE: out_valid=1, outputs stable. On out_ready, go to IDLE with out_valid=0 on the next cycle.
//  Latency: result is valid DVS_W+1 cycles after acceptance (9 at defaults). Exceptions take 1 cycle.
//  Throughput: one operation per DVS_W+2 cycles when out_ready is held high. No overlap of operations.
//  Exceptions, checked at acceptance:
//   divisor==0: div_by_zero=1, overflow=0, quotient={DVS_W{1'b1}}, remainder=dividend[DVS_W-1:0].
//   else if dividend[DVD_W-1:DVS_W] >= divisor: overflow=1, quotient={DVS_W{1'b1}}, remainder=dividend[DVS_W-1:0].
//   Otherwise both flags are 0, and dividend == quotient*divisor + remainder with remainder < divisor.
//  Flags are held only while out_valid=1 and are cleared on the IDLE transition.
//  in_valid while not in IDLE is ignored; the producer must hold its data until in_ready=1.
//  Result registers change only on entry to DONE; they are held while out_ready=0.
//  Every result register is DVS_W bits wide; there is no sign handling (unsigned only).
// STRUCTURE
//  Shared include (divu_defs.vh): FSM state localparams (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the width localparams.
//  One natural sub-module, div_step: combinational (DVS_W+1)-bit trial subtract.
//   Inputs r, divisor. Outputs r_next, qbit.
//   It can be swapped later for a non-restoring or CLA-based stage.
//  Top level: FSM, iteration counter ($clog2(DVS_W) bits), dividend shift register, remainder register,
//   quotient register, and output flag registers.
// TESTING
//  12345 (0x3039) / 200 -> quotient=61, remainder=145, both flags 0, out_valid exactly 9 cycles after acceptance.
//  0xFE01 / 255 -> quotient=255, remainder=0 (full-range round trip of 255*255).
//  0x1000 / 16 -> overflow=1, div_by_zero=0, quotient=0xFF, remainder=0x00, out_valid 1 cycle after acceptance.
//  0x1234 / 0 -> div_by_zero=1, overflow=0, quotient=0xFF, remainder=0x34.
//  Two back-to-back ops with out_ready held low 5 cycles: first result stays stable, in_ready=0 throughout,
//   second op is accepted only after the first handshake.
//  rst_n pulsed low during cycle 4 of CALC: outputs return to reset values immediately, no out_valid,
//   and a following op (100/7) -> quotient=14, remainder=2.
//  Random sweep against a reference model, plus all 256 divisors for dividend 0x00FF.

Source files
------------

// File: rtl/divu16x8_seq_pkg.sv
// Shared definitions for the iterative 16/8 unsigned divider: default widths and FSM encoding.
package divu16x8_seq_pkg;

    localparam int unsigned DefDvsW = 8;
    localparam int unsigned DefDvdW = 2 * DefDvsW;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/divu16x8_seq_div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted partial remainder.
module divu16x8_seq_div_step #(
    parameter int unsigned DVS_W = 8
) (
    input  logic [DVS_W:0]   r,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W:0]   r_next,
    output logic             qbit
);

    logic [DVS_W+1:0] diff;

    always_comb begin
        diff   = {1'b0, r} - {2'b00, divisor};
        // No borrow out of the extended difference means r >= divisor.
        qbit   = ~diff[DVS_W+1];
        r_next = qbit ? diff[DVS_W:0] : r;
    end

endmodule

// File: rtl/divu16x8_seq.sv
// Radix-2 restoring unsigned divider, DVD_W/DVS_W -> DVS_W quotient and remainder, one bit per clock.
module divu16x8_seq
    import divu16x8_seq_pkg::*;
#(
    parameter int unsigned DVS_W = DefDvsW,
    parameter int unsigned DVD_W = 2 * DVS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVS_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CNT_W = (DVS_W > 1) ? $clog2(DVS_W) : 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DVS_W - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [DVS_W-1:0] dvd_sh;
    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] quo_sh;
    logic [DVS_W-1:0] divisor_q;

    logic [DVS_W-1:0] dvd_hi;
    logic [DVS_W:0]   step_r;
    logic [DVS_W:0]   step_r_next;
    logic             step_qbit;
    logic [DVS_W-1:0] quo_next;

    // The upper half seeds the partial remainder; a non-overflowing operation guarantees it is
    // already below the divisor, so only the lower DVS_W dividend bits need to be shifted in.
    assign dvd_hi   = dividend[DVD_W-1:DVS_W];
    assign step_r   = {rem, dvd_sh[DVS_W-1]};
    assign quo_next = {quo_sh[DVS_W-2:0], step_qbit};

    // Partial remainder stays below the divisor after every step, so its MSB is always zero.
    logic unused_r_msb;
    logic unused_quo_msb;
    assign unused_r_msb   = step_r_next[DVS_W];
    assign unused_quo_msb = quo_sh[DVS_W-1];

    divu16x8_seq_div_step #(
        .DVS_W(DVS_W)
    ) u_div_step (
        .r      (step_r),
        .divisor(divisor_q),
        .r_next (step_r_next),
        .qbit   (step_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            cnt         <= '0;
            dvd_sh      <= '0;
            rem         <= '0;
            quo_sh      <= '0;
            divisor_q   <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        divisor_q <= divisor;
                        dvd_sh    <= dividend[DVS_W-1:0];
                        rem       <= dvd_hi;
                        quo_sh    <= '0;
                        cnt       <= '0;
                        in_ready  <= 1'b0;
                        if (divisor == '0) begin
                            state       <= StDone;
                            out_valid   <= 1'b1;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            quotient    <= '1;
                            remainder   <= dividend[DVS_W-1:0];
                        end else if (dvd_hi >= divisor) begin
                            state       <= StDone;
                            out_valid   <= 1'b1;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[DVS_W-1:0];
                        end else begin
                            state <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    rem    <= step_r_next[DVS_W-1:0];
                    quo_sh <= quo_next;
                    dvd_sh <= dvd_sh << 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CntLast) begin
                        state       <= StDone;
                        out_valid   <= 1'b1;
                        quotient    <= quo_next;
                        remainder   <= step_r_next[DVS_W-1:0];
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state       <= StIdle;
                        out_valid   <= 1'b0;
                        in_ready    <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divu16x8_seq.sv
// Directed and model-based checks for divu16x8_seq: vector table, handshake stalls and mid-op reset.
module tb_divu16x8_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int total;
    int passed;

    divu16x8_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    // Issue one operation, wait for the result, sample it, then complete the output handshake.
    task automatic do_op(input logic [15:0] dvd, input logic [7:0] dvs,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        ov = overflow;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic void ref_div(input logic [15:0] dvd, input logic [7:0] dvs,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic dz, output logic ov);
        logic [15:0] qq;
        logic [15:0] rr;
        dz = 1'b0;
        ov = 1'b0;
        if (dvs == 8'd0) begin
            dz = 1'b1;
            q  = 8'hFF;
            r  = dvd[7:0];
        end else if (dvd[15:8] >= dvs) begin
            ov = 1'b1;
            q  = 8'hFF;
            r  = dvd[7:0];
        end else begin
            qq = dvd / {8'd0, dvs};
            rr = dvd % {8'd0, dvs};
            q  = qq[7:0];
            r  = rr[7:0];
        end
    endfunction

    vec_t vecs[12];

    initial begin
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
        logic [7:0]  eq;
        logic [7:0]  er;
        logic        edz;
        logic        eov;
        logic [15:0] rd;
        logic [7:0]  rv;
        int          lat;
        int          n;
        int          sweep_bad;

        total = 0;
        passed = 0;

        vecs[0]  = '{16'h3039, 8'd200, 8'd61,  8'd145, 1'b0, 1'b0, 9};
        vecs[1]  = '{16'hFE01, 8'd255, 8'd255, 8'd0,   1'b0, 1'b0, 9};
        vecs[2]  = '{16'h1000, 8'd16,  8'hFF,  8'h00,  1'b0, 1'b1, 1};
        vecs[3]  = '{16'h1234, 8'd0,   8'hFF,  8'h34,  1'b1, 1'b0, 1};
        vecs[4]  = '{16'd100,  8'd7,   8'd14,  8'd2,   1'b0, 1'b0, 9};
        vecs[5]  = '{16'd0,    8'd1,   8'd0,   8'd0,   1'b0, 1'b0, 9};
        vecs[6]  = '{16'h00FF, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0, 9};
        vecs[7]  = '{16'h01FF, 8'd2,   8'd255, 8'd1,   1'b0, 1'b0, 9};
        vecs[8]  = '{16'h0200, 8'd2,   8'hFF,  8'h00,  1'b0, 1'b1, 1};
        vecs[9]  = '{16'hFFFF, 8'd0,   8'hFF,  8'hFF,  1'b1, 1'b0, 1};
        vecs[10] = '{16'h7FFF, 8'h80,  8'd255, 8'd127, 1'b0, 1'b0, 9};
        vecs[11] = '{16'd1000, 8'd250, 8'd4,   8'd0,   1'b0, 1'b0, 9};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_quotient", {24'd0, quotient}, 32'd0);
        chk("reset_remainder", {24'd0, remainder}, 32'd0);
        chk("reset_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].dvd, vecs[i].dvs, q, r, dz, ov, lat);
            chk($sformatf("vec%0d_quotient", i), {24'd0, q}, {24'd0, vecs[i].q});
            chk($sformatf("vec%0d_remainder", i), {24'd0, r}, {24'd0, vecs[i].r});
            chk($sformatf("vec%0d_div_by_zero", i), {31'd0, dz}, {31'd0, vecs[i].dz});
            chk($sformatf("vec%0d_overflow", i), {31'd0, ov}, {31'd0, vecs[i].ov});
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_flags_cleared", i), {30'd0, div_by_zero, overflow}, 32'd0);
            chk($sformatf("vec%0d_out_valid_drop", i), {31'd0, out_valid}, 32'd0);
        end

        // Back-to-back: first result held under out_ready=0 while the second op waits.
        dividend = 16'h3039;
        divisor  = 8'd200;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_first_latency", n, 9);
        dividend = 16'd100;
        divisor  = 8'd7;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_hold%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("b2b_hold%0d_quotient", c), {24'd0, quotient}, 32'd61);
            chk($sformatf("b2b_hold%0d_remainder", c), {24'd0, remainder}, 32'd145);
            chk($sformatf("b2b_hold%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_after_hs_in_ready", {31'd0, in_ready}, 32'd1);
        chk("b2b_after_hs_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_second_accepted", {31'd0, in_ready}, 32'd0);
        n = 1;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_second_latency", n, 9);
        chk("b2b_second_quotient", {24'd0, quotient}, 32'd14);
        chk("b2b_second_remainder", {24'd0, remainder}, 32'd2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset during the fourth CALC cycle discards the operation.
        dividend = 16'h3039;
        divisor  = 8'd200;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_quotient", {24'd0, quotient}, 32'd0);
        chk("midreset_remainder", {24'd0, remainder}, 32'd0);
        chk("midreset_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        chk("midreset_no_out_valid", n, 0);
        do_op(16'd100, 8'd7, q, r, dz, ov, lat);
        chk("postreset_quotient", {24'd0, q}, 32'd14);
        chk("postreset_remainder", {24'd0, r}, 32'd2);
        chk("postreset_latency", lat, 9);

        // Random sweep against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            rd = 16'($urandom);
            rv = 8'($urandom_range(0, 255));
            if (i % 2 == 0) rd[15:8] = 8'($urandom_range(0, 255)) % (rv == 8'd0 ? 8'd1 : rv);
            ref_div(rd, rv, eq, er, edz, eov);
            do_op(rd, rv, q, r, dz, ov, lat);
            chk($sformatf("rand%0d_%h_%h", i, rd, rv), {q, r, 6'd0, dz, ov, 8'd0},
                {eq, er, 6'd0, edz, eov, 8'd0});
        end

        // Every divisor for dividend 0x00FF.
        sweep_bad = 0;
        for (int d = 0; d < 256; d++) begin
            ref_div(16'h00FF, 8'(d), eq, er, edz, eov);
            do_op(16'h00FF, 8'(d), q, r, dz, ov, lat);
            if ({q, r, dz, ov} !== {eq, er, edz, eov}) begin
                sweep_bad++;
                $display("FAIL sweep_00ff_div%0d: got q=%0d r=%0d dz=%0b ov=%0b expected q=%0d r=%0d dz=%0b ov=%0b",
                         d, q, r, dz, ov, eq, er, edz, eov);
            end
        end
        chk("sweep_00ff_errors", sweep_bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
